// File: rtl/ram_stream_pkg.sv
// Shared types and defaults for the RAM stream reader.
package ram_stream_pkg;

   localparam int unsigned DEFAULT_DATA_WIDTH = 8;
   localparam int unsigned DEFAULT_RAM_DEPTH  = 256;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_t;

   // Address width for a RAM of the given depth; never narrower than one bit.
   function automatic int unsigned addr_width(input int unsigned depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/ram_stream_reader_if.sv
// Valid/ready word stream leaving the RAM reader.
interface ram_stream_reader_if
   import ram_stream_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

   logic [DATA_WIDTH-1:0] dout;
   logic                  dout_valid;
   logic                  dout_ready;

   modport master (output dout, output dout_valid, input dout_ready);
   modport slave  (input dout, input dout_valid, output dout_ready);

endinterface

// File: rtl/stream_skid_buffer.sv
// Two-entry buffer between the RAM read port and the output stream.
// Head register drives the stream directly; tail absorbs one word while stalled.
module stream_skid_buffer
   import ram_stream_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [1:0]            count
);

   logic [DATA_WIDTH-1:0] head_q, head_n;
   logic [DATA_WIDTH-1:0] tail_q, tail_n;
   logic [1:0]            count_q, count_n;
   logic                  valid_q;
   logic                  pop;

   assign pop = valid_q & out_ready;

   // Occupancy update; a push into a full buffer without a pop is prevented
   // upstream by the credit check, so it simply has no effect here.
   always_comb begin
      head_n  = head_q;
      tail_n  = tail_q;
      count_n = count_q;
      unique case (count_q)
         2'd0: begin
            if (in_valid) begin
               head_n  = in_data;
               count_n = 2'd1;
            end
         end
         2'd1: begin
            if (pop) begin
               if (in_valid) head_n = in_data;
               else          count_n = 2'd0;
            end else if (in_valid) begin
               tail_n  = in_data;
               count_n = 2'd2;
            end
         end
         2'd2: begin
            if (pop) begin
               head_n = tail_q;
               if (in_valid) tail_n = in_data;
               else          count_n = 2'd1;
            end
         end
         default: count_n = 2'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= 2'd0;
         valid_q <= 1'b0;
      end else begin
         head_q  <= head_n;
         tail_q  <= tail_n;
         count_q <= count_n;
         valid_q <= (count_n != 2'd0);
      end
   end

   assign out_valid = valid_q;
   assign out_data  = head_q;
   assign count     = count_q;

endmodule

// File: rtl/ram_stream_reader.sv
// Reads `length` consecutive RAM words from `base_addr` (wrapping) and streams
// them out with valid/ready, hiding the RAM's one-cycle read latency.
module ram_stream_reader
   import ram_stream_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = DEFAULT_DATA_WIDTH,
   parameter int unsigned RAM_DEPTH    = DEFAULT_RAM_DEPTH,
   parameter int unsigned LB_RAM_DEPTH = addr_width(RAM_DEPTH)
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    start,
   input  logic [LB_RAM_DEPTH-1:0] base_addr,
   input  logic [LB_RAM_DEPTH:0]   length,
   output logic                    busy,
   output logic                    done,
   output logic [LB_RAM_DEPTH-1:0] ram_addr,
   output logic                    ram_wr_en,
   input  logic [DATA_WIDTH-1:0]   ram_dout,
   ram_stream_reader_if.master     strm
);

   localparam int unsigned AW = LB_RAM_DEPTH;
   localparam int unsigned CW = LB_RAM_DEPTH + 1;

   state_t          state_q, state_n;
   logic            busy_q, busy_n;
   logic            done_q, done_n;
   logic [AW-1:0]   next_addr_q, next_addr_n;
   logic [AW-1:0]   ram_addr_q, ram_addr_n;
   logic [CW-1:0]   issue_cnt_q, issue_cnt_n;
   logic [CW-1:0]   beat_cnt_q, beat_cnt_n;
   logic            in_flight_q, in_flight_n;

   logic            skid_valid;
   logic [1:0]      skid_count;
   logic            accept;
   logic [2:0]      occupancy;
   logic            credit;

   stream_skid_buffer #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (in_flight_q),
      .in_data   (ram_dout),
      .out_valid (skid_valid),
      .out_ready (strm.dout_ready),
      .out_data  (strm.dout),
      .count     (skid_count)
   );

   assign strm.dout_valid = skid_valid;
   assign ram_wr_en       = 1'b0;
   assign busy            = busy_q;
   assign done            = done_q;
   assign ram_addr        = ram_addr_q;

   // Words owed to the skid after this edge: a beat leaving this cycle frees
   // its slot immediately, which keeps the pipe full at one word per cycle.
   assign accept    = skid_valid & strm.dout_ready;
   assign occupancy = 3'(in_flight_q) + 3'(skid_count) - 3'(accept);
   assign credit    = (occupancy < 3'd2);

   always_comb begin
      state_n     = state_q;
      busy_n      = busy_q;
      done_n      = 1'b0;
      next_addr_n = next_addr_q;
      ram_addr_n  = ram_addr_q;
      issue_cnt_n = issue_cnt_q;
      beat_cnt_n  = beat_cnt_q - CW'(accept);
      in_flight_n = 1'b0;

      unique case (state_q)
         IDLE: begin
            busy_n = 1'b0;
            // busy_q is still high here during the done cycle; start is ignored then.
            if (start && !busy_q) begin
               busy_n = 1'b1;
               if (length == '0) begin
                  done_n = 1'b1;
               end else begin
                  state_n     = RUN;
                  next_addr_n = base_addr;
                  issue_cnt_n = length;
                  beat_cnt_n  = length;
               end
            end
         end
         RUN: begin
            if (issue_cnt_q == '0) begin
               state_n = DRAIN;
            end else if (credit) begin
               ram_addr_n  = next_addr_q;
               next_addr_n = next_addr_q + AW'(1);
               issue_cnt_n = issue_cnt_q - CW'(1);
               in_flight_n = 1'b1;
               if (issue_cnt_q == CW'(1)) state_n = DRAIN;
            end
         end
         DRAIN: begin
            if (beat_cnt_n == '0) begin
               done_n  = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         next_addr_q <= '0;
         ram_addr_q  <= '0;
         issue_cnt_q <= '0;
         beat_cnt_q  <= '0;
         in_flight_q <= 1'b0;
      end else begin
         state_q     <= state_n;
         busy_q      <= busy_n;
         done_q      <= done_n;
         next_addr_q <= next_addr_n;
         ram_addr_q  <= ram_addr_n;
         issue_cnt_q <= issue_cnt_n;
         beat_cnt_q  <= beat_cnt_n;
         in_flight_q <= in_flight_n;
      end
   end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: RAM array model, randomized ready, queue-based
// expected stream built from the RAM contents.
module tb_ram_stream_reader;

   localparam int unsigned DW    = 8;
   localparam int unsigned DEPTH = 256;
   localparam int unsigned AW    = 8;

   logic          clk = 1'b0;
   logic          rstn;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW:0]   length;
   logic          busy;
   logic          done;
   logic [AW-1:0] ram_addr;
   logic          ram_wr_en;
   logic [DW-1:0] ram_dout;
   logic [DW-1:0] mem [DEPTH];

   int total = 0;
   int bad   = 0;

   ram_stream_reader_if #(.DATA_WIDTH(DW)) strm ();

   ram_stream_reader #(
      .DATA_WIDTH (DW),
      .RAM_DEPTH  (DEPTH)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .start     (start),
      .base_addr (base_addr),
      .length    (length),
      .busy      (busy),
      .done      (done),
      .ram_addr  (ram_addr),
      .ram_wr_en (ram_wr_en),
      .ram_dout  (ram_dout),
      .strm      (strm)
   );

   always #5 clk = ~clk;

   // ram_addr plays the role of the RAM's address register, so the read word follows it.
   assign ram_dout = mem[ram_addr];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic xfer(input int base, input int len, input bit rnd_ready,
                       input int restart_t, input int abort_after, input string nm);
      logic [DW-1:0] exp_q[$];
      int t, acc, done_cnt, done_t, last_acc_t, first_v;
      int stall_err, busy_err, max_ahead, ahead, quiet_err;
      logic pv, pr;
      logic [DW-1:0] pd;
      logic [AW-1:0] addr_before;
      bit aborted;

      for (int i = 0; i < len; i++) exp_q.push_back(mem[(base + i) % DEPTH]);
      acc = 0; done_cnt = 0; done_t = -1; last_acc_t = -1; first_v = -1;
      stall_err = 0; busy_err = 0; max_ahead = 0; quiet_err = 0;
      pv = 1'b0; pr = 1'b0; pd = '0; aborted = 1'b0;

      @(posedge clk); #1;
      start           = 1'b1;
      base_addr       = AW'(base);
      length          = (AW+1)'(len);
      strm.dout_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      addr_before     = ram_addr;
      @(posedge clk); #1;
      start = 1'b0;
      t = 0;

      while (!aborted && done_cnt == 0 && t < 3000) begin
         @(negedge clk);
         if (busy !== 1'b1) busy_err++;
         if (pv && !pr && (strm.dout_valid !== 1'b1 || strm.dout !== pd)) stall_err++;
         if (strm.dout_valid === 1'b1 && first_v < 0) first_v = t;
         if (t >= 1 && acc < len) begin
            ahead = ((int'(ram_addr) - base + 1 - acc) % int'(DEPTH) + int'(DEPTH)) % int'(DEPTH);
            if (ahead > max_ahead) max_ahead = ahead;
         end
         if (strm.dout_valid === 1'b1 && strm.dout_ready === 1'b1) begin
            if (exp_q.size() > 0) chk({nm, "/data"}, 32'(strm.dout), 32'(exp_q.pop_front()));
            acc++;
            last_acc_t = t;
         end
         if (done === 1'b1) begin
            done_cnt++;
            done_t = t;
         end
         pv = strm.dout_valid;
         pr = strm.dout_ready;
         pd = strm.dout;
         if (abort_after >= 0 && acc == abort_after) aborted = 1'b1;
         @(posedge clk); #1;
         t++;
         if (t == restart_t) begin
            start     = 1'b1;
            base_addr = AW'(100);
            length    = (AW+1)'(7);
         end else begin
            start = 1'b0;
         end
         if (rnd_ready) strm.dout_ready = 1'($urandom_range(0, 1));
      end

      if (aborted) begin
         rstn = 1'b0;
         @(posedge clk); #1;
         chk({nm, "/rst_busy"},  32'(busy), 0);
         chk({nm, "/rst_done"},  32'(done), 0);
         chk({nm, "/rst_valid"}, 32'(strm.dout_valid), 0);
         chk({nm, "/rst_dout"},  32'(strm.dout), 0);
         chk({nm, "/rst_addr"},  32'(ram_addr), 0);
         chk({nm, "/rst_wr_en"}, 32'(ram_wr_en), 0);
         rstn = 1'b1;
         repeat (4) begin
            @(negedge clk);
            if (done !== 1'b0 || strm.dout_valid !== 1'b0 || busy !== 1'b0) quiet_err++;
         end
         chk({nm, "/abort_quiet"}, 32'(quiet_err), 0);
         return;
      end

      chk({nm, "/done_count"}, 32'(done_cnt), 1);
      chk({nm, "/beats"}, 32'(acc), 32'(len));
      chk({nm, "/done_latency"}, 32'(done_t), 32'(last_acc_t + 1));
      chk({nm, "/stable"}, 32'(stall_err), 0);
      chk({nm, "/busy"}, 32'(busy_err), 0);
      if (len > 0) begin
         chk({nm, "/first_valid"}, 32'(first_v), 2);
         chk({nm, "/ahead_le_2"}, 32'(max_ahead <= 2), 1);
      end else begin
         chk({nm, "/no_valid"}, 32'(first_v), 32'(-1));
         chk({nm, "/addr_kept"}, 32'(ram_addr), 32'(addr_before));
      end
      repeat (4) begin
         @(negedge clk);
         if (busy !== 1'b0 || done !== 1'b0 || strm.dout_valid !== 1'b0) quiet_err++;
      end
      chk({nm, "/idle_after"}, 32'(quiet_err), 0);
   endtask

   initial begin
      rstn            = 1'b0;
      start           = 1'b0;
      base_addr       = '0;
      length          = '0;
      strm.dout_ready = 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] = DW'(i) ^ 8'hA5;

      repeat (3) @(posedge clk);
      #1;
      chk("reset/busy",  32'(busy), 0);
      chk("reset/done",  32'(done), 0);
      chk("reset/valid", 32'(strm.dout_valid), 0);
      chk("reset/dout",  32'(strm.dout), 0);
      chk("reset/addr",  32'(ram_addr), 0);
      chk("reset/wr_en", 32'(ram_wr_en), 0);
      rstn = 1'b1;

      xfer(0,   16, 1'b0, -1, -1, "base0_len16");
      xfer(250, 10, 1'b0, -1, -1, "wrap250");
      xfer(0,   32, 1'b1, -1, -1, "rand_ready32");
      xfer(77,   0, 1'b0, -1, -1, "len0");
      xfer(0,   64, 1'b0, -1, 20, "abort64");
      xfer(5,    3, 1'b0, -1, -1, "after_abort");
      xfer(40,  12, 1'b1,  5, -1, "restart_ignored");

      for (int n = 0; n < 6; n++) begin
         xfer(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 40)),
              1'($urandom_range(0, 1)), -1, -1, "random");
      end
      for (int i = 0; i < int'(DEPTH); i++) mem[i] = DW'($urandom);
      xfer(int'($urandom_range(0, DEPTH - 1)), int'(DEPTH), 1'b1, -1, -1, "full_depth");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ram_stream_reader.md
Name: ram_stream_reader

Overview:
- Read-side engine for dual_port_RAM. It is the reader counterpart to the write path that fills the RAM.
- On a start command it reads `length` consecutive words beginning at `base_addr`, wrapping modulo RAM_DEPTH.
- It presents the words as a valid/ready stream and absorbs the RAM's 1-cycle read latency without losing throughput.
- It drives one RAM port (read-only); the other port stays with the writer.

Parameters:
- DATA_WIDTH, 8, word width; must match dual_port_RAM.
- RAM_DEPTH, 256, RAM words; power of two, at least 2.
- LB_RAM_DEPTH, $clog2(RAM_DEPTH), address width (derived; not overridden).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rstn  in  1  synchronous active-low reset.
- start  in  1  command pulse; sampled only in IDLE.
- base_addr  in  LB_RAM_DEPTH  first address to read.
- length  in  LB_RAM_DEPTH+1  word count, 0..RAM_DEPTH.
- busy  out  1  high from the accepted start until the done cycle, inclusive.
- done  out  1  1-cycle pulse after the last word is accepted downstream.
- ram_addr  out  LB_RAM_DEPTH  to dual_port_RAM addrN.
- ram_wr_en  out  1  to wr_enN; constant 0.
- ram_dout  in  DATA_WIDTH  from doutN; valid the cycle after the edge that samples ram_addr.
- dout  out  DATA_WIDTH  stream data.
- dout_valid  out  1  stream valid.
- dout_ready  in  1  stream ready.

Behaviour:
- Reset (rstn=0 at posedge):
  - Outputs: busy=0, done=0, dout_valid=0, dout=0, ram_addr=0, ram_wr_en=0.
  - Internal: FSM=IDLE, counters cleared, skid buffer emptied.
  - Reset mid-transfer aborts the transfer: no done pulse; words in flight are discarded.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE:
    - start=1 and length>0 -> RUN. Latch next_addr=base_addr, issue_cnt=length, beat_cnt=length. busy=1 from the next cycle.
    - start=1 and length=0 -> done=1 the next cycle. busy=1 for that one cycle only. No RAM reads and no beats.
  - RUN:
    - Issue a read when issue_cnt>0 and credit is available: ram_addr<=next_addr, next_addr<=next_addr+1 (wraps at RAM_DEPTH naturally by width), issue_cnt--.
    - Credit rule: (reads in flight + words held in skid) < 2. This guarantees no overflow under any ready pattern.
    - Each returned ram_dout is captured into the skid buffer in the cycle after its issue.
    - Go to DRAIN when issue_cnt reaches 0.
  - DRAIN:
    - Wait until beat_cnt reaches 0 (decremented on each dout_valid & dout_ready).
    - Then pulse done=1 for 1 cycle with busy=1 in the same cycle, and return to IDLE. busy=0 from the next cycle.
- Stream rules (AXI-style):
  - Once dout_valid=1, dout must hold stable until dout_ready=1.
  - dout_valid must not depend combinationally on dout_ready.
- Throughput and latency:
  - With dout_ready held at 1, sustained throughput is 1 word per cycle.
  - First dout_valid appears 2 cycles after the start edge: edge0 latches the command, edge1 samples ram_addr, edge2 captures the data.
- start while busy is ignored; the command inputs are not re-latched.
- Simultaneous events: a capture into the skid buffer and a downstream accept in the same cycle are both handled, and occupancy stays consistent.
- length=RAM_DEPTH reads every word exactly once, wrapping from base_addr back to base_addr-1.

Decomposition:
- Package ram_stream_pkg:
  - state_t enum {IDLE, RUN, DRAIN}.
  - Function for the address-width derivation.
  - Shared DATA_WIDTH/RAM_DEPTH defaults.
- Sub-module stream_skid_buffer (2-entry, DATA_WIDTH param):
  - in_valid/in_data upstream.
  - out_valid/out_ready/out_data downstream.
  - count output, used for the credit rule.
- The top level holds the FSM, address/issue/beat counters and RAM port drive, and instantiates dual_port_RAM only in the bench.

Test Plan:
- Preload the RAM with addr i -> data i^8'hA5. start with base=0, length=16, ready=1 -> dout sequence 8'hA5, 8'hA4, ... 16 consecutive beats; first valid 2 cycles after start; done 1 cycle after the 16th accept.
- base=250, length=10, ready=1 -> beats from addresses 250..255 then 0..3, in order; no duplicate or skipped words.
- base=0, length=32, dout_ready random 50% -> all 32 words in order. dout is stable while valid&!ready. ram_addr never runs more than 2 ahead of accepted beats.
- start with length=0 -> done=1 the next cycle, busy high 1 cycle, dout_valid never asserts, ram_addr unchanged.
- Mid-transfer (length=64, after 20 beats): rstn=0 for 1 cycle -> all outputs at reset values the following cycle. No done pulse. A new start with base=5, length=3 then yields data for addresses 5, 6, 7.
- start pulsed again while busy (base=100) -> ignored; the original transfer completes with the correct count and a single done.
